// File: rtl/reset_sequencer.sv
// Power-up / soft-reset sequencer: merges PLL lock and debounced soft-reset requests into
// one abort cause, then releases N_OUT reset domains in order after a hold period.
module reset_sequencer #(
    parameter int N_SRC       = 3,
    parameter int N_OUT       = 3,
    parameter int HOLD_CYCLES = 256,
    parameter int STAGE_GAP   = 16,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic [N_SRC-1:0] rst_req,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready,
    output logic [N_SRC:0]   cause
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int SW      = $clog2(N_OUT + 1);
    localparam int DW      = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(N_OUT);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE);

    typedef enum logic [1:0] {HOLD, COUNT, STAGE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    s_q, s_d;
    logic [N_OUT-1:0] rst_out_q, rst_out_d;
    logic [N_SRC:0]   cause_q, cause_d;

    logic             lock_meta_q, lock_s_q;
    logic [N_SRC-1:0] req_meta_q, req_s_q;
    logic [N_SRC-1:0] req_db;
    logic             abort;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            req_meta_q  <= '0;
            req_s_q     <= '0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
            req_meta_q  <= rst_req;
            req_s_q     <= req_meta_q;
        end
    end

    // Saturating per-source counter; any low sample drops the request at once.
    for (genvar g = 0; g < N_SRC; g++) begin : g_db
        logic [DW-1:0] db_q;

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset)
                db_q <= '0;
            else if (!req_s_q[g])
                db_q <= '0;
            else if (db_q != DB_MAX)
                db_q <= db_q + DW'(1);
        end

        assign req_db[g] = (db_q == DB_MAX);
    end

    assign abort = ~lock_s_q | (|req_db);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cause_d = cause_q;
        if (state_q != HOLD && abort) begin
            state_d = HOLD;
            cnt_d   = '0;
            s_d     = '0;
            cause_d = {~lock_s_q, req_db};
        end else begin
            case (state_q)
                HOLD: begin
                    cnt_d = '0;
                    s_d   = '0;
                    if (!abort) state_d = COUNT;
                end
                COUNT: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        s_d     = SW'(1);
                        state_d = (S_LAST == SW'(1)) ? RUN : STAGE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STAGE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        s_d   = s_q + SW'(1);
                        if (s_d == S_LAST) state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
        // Outputs are decoded from next-state s so they change on the same edge as s.
        rst_out_d = '0;
        for (int i = 0; i < N_OUT; i++)
            rst_out_d[i] = (s_d <= SW'(i));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            s_q       <= '0;
            rst_out_q <= '1;
            cause_q   <= {1'b1, {N_SRC{1'b0}}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            rst_out_q <= rst_out_d;
            cause_q   <= cause_d;
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = (state_q == RUN);
    assign cause   = cause_q;

endmodule
